// File: rtl/cam_pixel_capture.sv
// OV7670 capture front end: oversamples the camera bus on CLK100MHZ, pairs RGB565 bytes and
// issues linear frame-buffer writes. Define CAM_GRAY_EN for replicated 4-bit luma output.
module cam_pixel_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned AWIDTH   = 19,
  parameter int unsigned DWIDTH   = 12
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              pclk_cam,
  input  logic              vsync_cam,
  input  logic              href_cam,
  input  logic [7:0]        wdata_cam,
  input  logic              capture_en,
  output logic [AWIDTH-1:0] waddr_cam,
  output logic [DWIDTH-1:0] wdata_cam_pix,
  output logic              wen_cam,
  output logic              frame_done,
  output logic [AWIDTH-1:0] pix_count,
  output logic [1:0]        err_flags,
  output logic [1:0]        state_debug
);

  localparam logic [AWIDTH-1:0] FrameSize = AWIDTH'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StVblank = 2'd1,
    StActive = 2'd2,
    StSkip   = 2'd3
  } state_e;

  // Camera inputs are plain data here: two sync flops each, plus a history flop for edges.
  logic       pclk_s1, pclk_s2, pclk_s3;
  logic       vsync_s1, vsync_s2, vsync_s3;
  logic       href_s1, href_s2, href_s3;
  logic [7:0] data_s1, data_s2;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      pclk_s1  <= 1'b0;
      pclk_s2  <= 1'b0;
      pclk_s3  <= 1'b0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      vsync_s3 <= 1'b0;
      href_s1  <= 1'b0;
      href_s2  <= 1'b0;
      href_s3  <= 1'b0;
      data_s1  <= '0;
      data_s2  <= '0;
    end else begin
      pclk_s1  <= pclk_cam;
      pclk_s2  <= pclk_s1;
      pclk_s3  <= pclk_s2;
      vsync_s1 <= vsync_cam;
      vsync_s2 <= vsync_s1;
      vsync_s3 <= vsync_s2;
      href_s1  <= href_cam;
      href_s2  <= href_s1;
      href_s3  <= href_s2;
      data_s1  <= wdata_cam;
      data_s2  <= data_s1;
    end
  end

  logic pclk_rise, vsync_rise, vsync_fall, href_fall;

  assign pclk_rise  = pclk_s2 & ~pclk_s3;
  assign vsync_rise = vsync_s2 & ~vsync_s3;
  assign vsync_fall = ~vsync_s2 & vsync_s3;
  assign href_fall  = ~href_s2 & href_s3;

  state_e state_q, state_d;
  logic   start_frame, end_frame;

  // IDLE waits for a vsync-high period so a frame already in flight at reset is never taken.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (vsync_s2) state_d = StVblank;
      end
      StVblank: begin
        if (vsync_fall) begin
          if (capture_en) begin
            state_d     = StActive;
            start_frame = 1'b1;
          end else begin
            state_d = StSkip;
          end
        end
      end
      StActive: begin
        if (vsync_rise) begin
          state_d   = StVblank;
          end_frame = 1'b1;
        end
      end
      StSkip: begin
        if (vsync_rise) state_d = StVblank;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  logic              phase_q;
  logic [7:0]        hi_q;
  logic [AWIDTH-1:0] addr_q;
  logic              wen_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              frame_done_q;
  logic [AWIDTH-1:0] pix_count_q;
  logic [1:0]        err_q;

  logic              byte_take, pix_form, pix_ok, pix_drop, odd_line;
  logic [AWIDTH-1:0] in_flight;

  assign byte_take = (state_q == StActive) && pclk_rise && href_s2;
  assign pix_form  = byte_take && phase_q;
  assign pix_ok    = pix_form && (addr_q != FrameSize);
  assign pix_drop  = pix_form && (addr_q == FrameSize);
  assign odd_line  = (state_q == StActive) && href_fall && phase_q;

`ifdef CAM_GRAY_EN
  logic        gray_vld_q;
  logic [15:0] gray_raw_q;
  logic [4:0]  gray_r, gray_g, gray_b;
  logic [7:0]  gray_sum;
  logic        unused_gray_bits;

  // Y = (2R + 5G + B) / 8 on 5-bit channels; the upper four bits of Y land in sum[7:4].
  assign gray_r           = gray_raw_q[15:11];
  assign gray_g           = gray_raw_q[10:6];
  assign gray_b           = gray_raw_q[4:0];
  assign gray_sum         = {2'b00, gray_r, 1'b0} + ({3'b000, gray_g} * 8'd5) +
                            {3'b000, gray_b};
  assign unused_gray_bits = ^{gray_raw_q[5], gray_sum[3:0]};
  assign in_flight        = AWIDTH'(wen_q) + AWIDTH'(gray_vld_q) + AWIDTH'(pix_ok);

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      gray_vld_q <= 1'b0;
      gray_raw_q <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
    end else begin
      gray_vld_q <= pix_ok;
      if (pix_ok) gray_raw_q <= {hi_q, data_s2};
      wen_q <= gray_vld_q;
      if (gray_vld_q) wdata_q <= {gray_sum[7:4], gray_sum[7:4], gray_sum[7:4]};
    end
  end
`else
  logic unused_pix_bits;

  assign unused_pix_bits = ^{hi_q[3], data_s2[6:5], data_s2[0]};
  assign in_flight       = AWIDTH'(wen_q) + AWIDTH'(pix_ok);

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      wen_q <= pix_ok;
      if (pix_ok) wdata_q <= {hi_q[7:4], hi_q[2:0], data_s2[7], data_s2[4:1]};
    end
  end
`endif

  // pix_count includes a pixel still in the write pipeline when vsync rises.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      phase_q      <= 1'b0;
      hi_q         <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      pix_count_q  <= '0;
      err_q        <= '0;
    end else begin
      frame_done_q <= end_frame;
      if (end_frame) pix_count_q <= addr_q + in_flight;
      err_q <= err_q | {odd_line, pix_drop};
      if (start_frame) begin
        phase_q <= 1'b0;
        addr_q  <= '0;
      end else begin
        if (byte_take) begin
          phase_q <= ~phase_q;
        end else if (odd_line) begin
          phase_q <= 1'b0;
        end
        if (byte_take && !phase_q) hi_q <= data_s2;
        if (wen_q) addr_q <= addr_q + AWIDTH'(1);
      end
    end
  end

  assign waddr_cam     = addr_q;
  assign wdata_cam_pix = wdata_q;
  assign wen_cam       = wen_q;
  assign frame_done    = frame_done_q;
  assign pix_count     = pix_count_q;
  assign err_flags     = err_q;
  assign state_debug   = state_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture; V_ACTIVE is shrunk so the overflow frame stays short.
module tb_cam_pixel_capture;

  localparam int unsigned HA = 640;
  localparam int unsigned VA = 4;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 12;

`ifdef CAM_GRAY_EN
  localparam logic [11:0] PixRed   = 12'h333;
  localparam logic [11:0] PixGreen = 12'h999;
  localparam logic [11:0] PixBlue  = 12'h111;
  localparam logic [11:0] PixWhite = 12'hFFF;
  localparam int          LatExp   = 4;
`else
  localparam logic [11:0] PixRed   = 12'hF00;
  localparam logic [11:0] PixGreen = 12'h0F0;
  localparam logic [11:0] PixBlue  = 12'h00F;
  localparam logic [11:0] PixWhite = 12'hFFF;
  localparam int          LatExp   = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pclk_cam;
  logic          vsync_cam;
  logic          href_cam;
  logic [7:0]    wdata_cam;
  logic          capture_en;
  logic [AW-1:0] waddr_cam;
  logic [DW-1:0] wdata_cam_pix;
  logic          wen_cam;
  logic          frame_done;
  logic [AW-1:0] pix_count;
  logic [1:0]    err_flags;
  logic [1:0]    state_debug;

  always #5 clk = ~clk;

  cam_pixel_capture #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .AWIDTH  (AW),
    .DWIDTH  (DW)
  ) dut (
    .CLK100MHZ    (clk),
    .rst          (rst),
    .pclk_cam     (pclk_cam),
    .vsync_cam    (vsync_cam),
    .href_cam     (href_cam),
    .wdata_cam    (wdata_cam),
    .capture_en   (capture_en),
    .waddr_cam    (waddr_cam),
    .wdata_cam_pix(wdata_cam_pix),
    .wen_cam      (wen_cam),
    .frame_done   (frame_done),
    .pix_count    (pix_count),
    .err_flags    (err_flags),
    .state_debug  (state_debug)
  );

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  int            fd_total = 0;
  int            wbase = 0;
  int            fbase = 0;

  // Write/frame_done log; tests only read it, relative to a base taken at frame start.
  always @(negedge clk) begin
    if (wen_cam) begin
      q_addr.push_back(waddr_cam);
      q_data.push_back(wdata_cam_pix);
    end
    if (frame_done) fd_total++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic int nwr();
    return q_addr.size() - wbase;
  endfunction

  function automatic int addr_errs();
    int n = 0;
    for (int i = wbase; i < q_addr.size(); i++) if (q_addr[i] !== AW'(i - wbase)) n++;
    return n;
  endfunction

  function automatic int data_errs(input logic [DW-1:0] exp);
    int n = 0;
    for (int i = wbase; i < q_data.size(); i++) if (q_data[i] !== exp) n++;
    return n;
  endfunction

  task automatic mark();
    wbase = q_addr.size();
    fbase = fd_total;
  endtask

  task automatic cam_byte(input logic [7:0] b);
    @(negedge clk);
    pclk_cam  = 1'b0;
    href_cam  = 1'b1;
    wdata_cam = b;
    repeat (2) @(negedge clk);
    pclk_cam = 1'b1;
    @(negedge clk);
  endtask

  task automatic cam_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pclk_cam  = 1'b0;
      href_cam  = 1'b0;
      wdata_cam = 8'h00;
      repeat (2) @(negedge clk);
      pclk_cam = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic cam_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < nbytes; i++) cam_byte((i % 2 == 0) ? b0 : b1);
    cam_idle(2);
  endtask

  task automatic set_vsync(input logic v);
    @(negedge clk);
    vsync_cam = v;
    repeat (8) @(negedge clk);
  endtask

  task automatic start_frame(input logic en);
    capture_en = en;
    set_vsync(1'b1);
    mark();
    set_vsync(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; pclk_cam = 1'b0; vsync_cam = 1'b0; href_cam = 1'b0;
    wdata_cam = 8'h00; capture_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (wen_cam !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0h want 0", wen_cam); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %0h want 0", frame_done); end
    checks++; if (waddr_cam !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", waddr_cam); end
    checks++; if (wdata_cam_pix !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", wdata_cam_pix); end
    checks++; if (pix_count !== '0) begin errors++; $display("FAIL reset_cnt: got %0h want 0", pix_count); end
    checks++; if (err_flags !== 2'b00) begin errors++; $display("FAIL reset_err: got %0h want 0", err_flags); end
    checks++; if (state_debug !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_debug); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (state_debug !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", state_debug); end
    set_vsync(1'b1);
    checks++; if (state_debug !== 2'd1) begin errors++; $display("FAIL idle_to_vblank: got %0d want 1", state_debug); end
  endtask

  task automatic test_red_frame();
    capture_en = 1'b1;
    mark();
    set_vsync(1'b0);
    checks++; if (state_debug !== 2'd2) begin errors++; $display("FAIL red_active: got %0d want 2", state_debug); end
    repeat (2) cam_line(2 * HA, 8'hF8, 8'h00);
    set_vsync(1'b1);
    checks++; if (nwr() !== 1280) begin errors++; $display("FAIL red_writes: got %0d want 1280", nwr()); end
    checks++; if (addr_errs() !== 0) begin errors++; $display("FAIL red_addr: got %0d bad want 0", addr_errs()); end
    checks++; if (data_errs(PixRed) !== 0) begin errors++; $display("FAIL red_data: got %0d bad want 0", data_errs(PixRed)); end
    checks++; if (fd_total - fbase !== 1) begin errors++; $display("FAIL red_fd: got %0d want 1", fd_total - fbase); end
    checks++; if (pix_count !== AW'(1280)) begin errors++; $display("FAIL red_cnt: got %0d want 1280", pix_count); end
    checks++; if (err_flags !== 2'b00) begin errors++; $display("FAIL red_err: got %0h want 0", err_flags); end
    checks++; if (state_debug !== 2'd1) begin errors++; $display("FAIL red_vblank: got %0d want 1", state_debug); end
  endtask

  task automatic test_latency_colors();
    int lat;
    start_frame(1'b1);
    cam_byte(8'hF8);
    @(negedge clk);
    pclk_cam  = 1'b0;
    wdata_cam = 8'h00;
    repeat (2) @(negedge clk);
    pclk_cam = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (wen_cam) break;
    end
    checks++; if (lat !== LatExp) begin errors++; $display("FAIL latency: got %0d want %0d", lat, LatExp); end
    cam_byte(8'h07); cam_byte(8'hE0);
    cam_byte(8'h00); cam_byte(8'h1F);
    cam_byte(8'hFF); cam_byte(8'hFF);
    cam_idle(2);
    set_vsync(1'b1);
    checks++; if (nwr() !== 4) begin errors++; $display("FAIL col_writes: got %0d want 4", nwr()); end
    if (nwr() == 4) begin
      checks++; if (q_data[wbase] !== PixRed) begin errors++; $display("FAIL col_red: got %0h want %0h", q_data[wbase], PixRed); end
      checks++; if (q_data[wbase+1] !== PixGreen) begin errors++; $display("FAIL col_green: got %0h want %0h", q_data[wbase+1], PixGreen); end
      checks++; if (q_data[wbase+2] !== PixBlue) begin errors++; $display("FAIL col_blue: got %0h want %0h", q_data[wbase+2], PixBlue); end
      checks++; if (q_data[wbase+3] !== PixWhite) begin errors++; $display("FAIL col_white: got %0h want %0h", q_data[wbase+3], PixWhite); end
    end
    checks++; if (addr_errs() !== 0) begin errors++; $display("FAIL col_addr: got %0d bad want 0", addr_errs()); end
    checks++; if (pix_count !== AW'(4)) begin errors++; $display("FAIL col_cnt: got %0d want 4", pix_count); end
  endtask

  task automatic test_simultaneous();
    start_frame(1'b1);
    for (int i = 0; i < 6; i++) cam_byte((i % 2 == 0) ? 8'hF8 : 8'h00);
    cam_byte(8'hF8);
    @(negedge clk);
    pclk_cam  = 1'b0;
    wdata_cam = 8'h00;
    repeat (2) @(negedge clk);
    pclk_cam  = 1'b1;
    vsync_cam = 1'b1;
    repeat (8) @(negedge clk);
    cam_idle(2);
    checks++; if (nwr() !== 4) begin errors++; $display("FAIL simul_writes: got %0d want 4", nwr()); end
    checks++; if (pix_count !== AW'(4)) begin errors++; $display("FAIL simul_cnt: got %0d want 4", pix_count); end
    checks++; if (fd_total - fbase !== 1) begin errors++; $display("FAIL simul_fd: got %0d want 1", fd_total - fbase); end
    checks++; if (addr_errs() !== 0) begin errors++; $display("FAIL simul_addr: got %0d bad want 0", addr_errs()); end
  endtask

  task automatic test_overflow();
    start_frame(1'b1);
    repeat (VA) cam_line(2 * HA, 8'hF8, 8'h00);
    cam_line(8, 8'hF8, 8'h00);
    set_vsync(1'b1);
    checks++; if (nwr() !== HA * VA) begin errors++; $display("FAIL ovf_writes: got %0d want %0d", nwr(), HA * VA); end
    checks++; if (q_addr[q_addr.size()-1] !== AW'(HA * VA - 1)) begin errors++; $display("FAIL ovf_last: got %0d want %0d", q_addr[q_addr.size()-1], HA * VA - 1); end
    checks++; if (addr_errs() !== 0) begin errors++; $display("FAIL ovf_addr: got %0d bad want 0", addr_errs()); end
    checks++; if (pix_count !== AW'(HA * VA)) begin errors++; $display("FAIL ovf_cnt: got %0d want %0d", pix_count, HA * VA); end
    checks++; if (err_flags !== 2'b01) begin errors++; $display("FAIL ovf_err: got %0h want 1", err_flags); end
  endtask

  task automatic test_odd_line();
    int first;
    start_frame(1'b1);
    cam_line(2 * HA - 1, 8'hF8, 8'h00);
    first = nwr();
    cam_line(2 * HA, 8'hF8, 8'h00);
    set_vsync(1'b1);
    checks++; if (first !== HA - 1) begin errors++; $display("FAIL odd_first: got %0d want %0d", first, HA - 1); end
    checks++; if (nwr() !== 2 * HA - 1) begin errors++; $display("FAIL odd_writes: got %0d want %0d", nwr(), 2 * HA - 1); end
    checks++; if (addr_errs() !== 0) begin errors++; $display("FAIL odd_addr: got %0d bad want 0", addr_errs()); end
    checks++; if (data_errs(PixRed) !== 0) begin errors++; $display("FAIL odd_data: got %0d bad want 0", data_errs(PixRed)); end
    checks++; if (pix_count !== AW'(2 * HA - 1)) begin errors++; $display("FAIL odd_cnt: got %0d want %0d", pix_count, 2 * HA - 1); end
    checks++; if (err_flags !== 2'b11) begin errors++; $display("FAIL odd_err: got %0h want 3", err_flags); end
  endtask

  task automatic test_skip();
    start_frame(1'b0);
    checks++; if (state_debug !== 2'd3) begin errors++; $display("FAIL skip_state: got %0d want 3", state_debug); end
    capture_en = 1'b1;
    cam_line(32, 8'hF8, 8'h00);
    set_vsync(1'b1);
    checks++; if (nwr() !== 0) begin errors++; $display("FAIL skip_writes: got %0d want 0", nwr()); end
    checks++; if (fd_total - fbase !== 0) begin errors++; $display("FAIL skip_fd: got %0d want 0", fd_total - fbase); end
    checks++; if (state_debug !== 2'd1) begin errors++; $display("FAIL skip_vblank: got %0d want 1", state_debug); end
    start_frame(1'b1);
    cam_line(16, 8'h00, 8'h1F);
    set_vsync(1'b1);
    checks++; if (nwr() !== 8) begin errors++; $display("FAIL skip_next_writes: got %0d want 8", nwr()); end
    checks++; if (addr_errs() !== 0) begin errors++; $display("FAIL skip_next_addr: got %0d bad want 0", addr_errs()); end
    checks++; if (data_errs(PixBlue) !== 0) begin errors++; $display("FAIL skip_next_data: got %0d bad want 0", data_errs(PixBlue)); end
    checks++; if (pix_count !== AW'(8)) begin errors++; $display("FAIL skip_next_cnt: got %0d want 8", pix_count); end
  endtask

  task automatic test_reset_mid();
    start_frame(1'b1);
    for (int i = 0; i < 200; i++) cam_byte((i % 2 == 0) ? 8'hF8 : 8'h00);
    cam_byte(8'hF8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (wen_cam !== 1'b0) begin errors++; $display("FAIL mid_wen: got %0h want 0", wen_cam); end
    checks++; if (waddr_cam !== '0) begin errors++; $display("FAIL mid_addr: got %0d want 0", waddr_cam); end
    checks++; if (wdata_cam_pix !== '0) begin errors++; $display("FAIL mid_data: got %0h want 0", wdata_cam_pix); end
    checks++; if (pix_count !== '0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", pix_count); end
    checks++; if (err_flags !== 2'b00) begin errors++; $display("FAIL mid_err: got %0h want 0", err_flags); end
    checks++; if (state_debug !== 2'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", state_debug); end
    rst = 1'b0;
    mark();
    cam_line(40, 8'hF8, 8'h00);
    checks++; if (nwr() !== 0) begin errors++; $display("FAIL mid_blocked: got %0d want 0", nwr()); end
    checks++; if (state_debug !== 2'd0) begin errors++; $display("FAIL mid_idle: got %0d want 0", state_debug); end
    start_frame(1'b1);
    cam_line(8, 8'h07, 8'hE0);
    set_vsync(1'b1);
    checks++; if (nwr() !== 4) begin errors++; $display("FAIL mid_new_writes: got %0d want 4", nwr()); end
    checks++; if (addr_errs() !== 0) begin errors++; $display("FAIL mid_new_addr: got %0d bad want 0", addr_errs()); end
    checks++; if (data_errs(PixGreen) !== 0) begin errors++; $display("FAIL mid_new_data: got %0d bad want 0", data_errs(PixGreen)); end
    checks++; if (pix_count !== AW'(4)) begin errors++; $display("FAIL mid_new_cnt: got %0d want 4", pix_count); end
  endtask

  initial begin
    test_reset();
    test_red_frame();
    test_latency_colors();
    test_simultaneous();
    test_overflow();
    test_odd_line();
    test_skip();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Sits between the OV7670 parallel bus and the frame-buffer write port of the memory controller.
- Oversamples the camera pclk/vsync/href/data in the CLK100MHZ domain.
- Pairs RGB565 bytes into 12-bit pixels.
- Issues one-cycle write strobes with linear frame-buffer addresses, plus frame-level status for debug.

Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- AWIDTH, 19, frame-buffer address width
- DWIDTH, 12, pixel width (4:4:4)

Ports:
- CLK100MHZ  in  1  system clock, sole clock
- rst  in  1  synchronous active-high reset
- pclk_cam  in  1  camera pixel clock, asynchronous; treated as data
- vsync_cam  in  1  camera vsync, high during vertical blank
- href_cam  in  1  camera line-valid
- wdata_cam  in  8  camera data byte
- capture_en  in  1  allows capture of the next frame
- waddr_cam  out  AWIDTH  write address
- wdata_cam_pix  out  DWIDTH  write pixel
- wen_cam  out  1  write strobe, one cycle per pixel
- frame_done  out  1  one-cycle pulse at end of a captured frame
- pix_count  out  AWIDTH  pixels written in last completed frame
- err_flags  out  2  sticky: [0] overflow, [1] odd-byte line
- state_debug  out  2  current FSM state encoding

Behaviour:
- Synchronizer:
  - pclk, vsync, href and data each pass through 2 flops.
  - pclk has a third flop; pclk_rise = s2 & ~s3.
  - All sampling uses the stage-2 values on the pclk_rise cycle.
- Reset values:
  - waddr_cam, wdata_cam_pix, pix_count = 0
  - wen_cam, frame_done, err_flags = 0
  - byte phase = 0
  - state = IDLE (encoding 0)
- FSM:
  - IDLE(0): wait for synced vsync=1, then go to VBLANK. This guarantees no partial frame after reset.
  - VBLANK(1): on vsync falling edge, go to ACTIVE if capture_en=1 that cycle, else SKIP. Entering ACTIVE clears the address counter and byte phase.
  - SKIP(3): on vsync rising edge, go to VBLANK. No writes; frame_done stays low.
  - ACTIVE(2):
    - On pclk_rise with href=1 and phase=0: store byte as hi, set phase=1.
    - On pclk_rise with href=1 and phase=1: form the pixel, set phase=0.
    - On vsync rising edge: latch pix_count = address counter, pulse frame_done for 1 cycle, go to VBLANK.
- Pixel format:
  - hi = {R4..R0,G5..G3}; lo = {G2..G0,B4..B0}.
  - wdata_cam_pix = {R4:R1, G5:G2, B4:B1}.
- Latency and write rules:
  - wen_cam asserts the cycle after the second-byte pclk_rise.
  - waddr_cam and wdata_cam_pix are valid in that same cycle.
  - The address counter increments in the cycle after wen_cam.
- Address order is linear: line*H_ACTIVE + column.
- Overflow: when the counter equals H_ACTIVE*V_ACTIVE (307200), further pixels are dropped (no wen_cam), the counter holds, and err_flags[0] is set.
- Odd-byte line: href falling while phase=1 discards the partial byte, resets phase to 0 and sets err_flags[1].
- Simultaneous events: a vsync rising edge in the same cycle as a second-byte pclk_rise writes that pixel first; frame_done then pulses the following cycle, and pix_count includes that pixel.
- capture_en is sampled only at the VBLANK→ACTIVE decision. Deasserting it mid-frame does not abort the frame.
- err_flags clear only on rst.
- Reset mid-frame: all outputs return to reset values the next cycle, and the FSM re-enters IDLE.

Optional Feature:
- CAM_GRAY_EN
- Defined:
  - Y = (2R5 + 5G5 + B5)/8 using 5-bit expansions (G5 = G5:G1), computed in one extra register stage.
  - wdata_cam_pix = {Y4:Y1, Y4:Y1, Y4:Y1}.
  - wen_cam latency becomes 2 cycles after the second-byte pclk_rise. Address timing moves with it.
- Undefined: color path as above, latency 1.

Test Plan:
- Reset, then vsync high→low, capture_en=1, then 2 lines of 640 pixels (bytes 0xF8,0x00 = pure red) at 25 MHz pclk, then vsync rise → wen_cam exactly 1280 times, data 0xF00, addresses 0..1279, frame_done one pulse, pix_count=1280, err_flags=0.
- Bytes 0x07,0xE0 (pure green), then 0x00,0x1F (blue) → wdata_cam_pix 0x0F0 then 0x00F. With CAM_GRAY_EN, 0xFF,0xFF → 0xFFF.
- Full 640x480 frame plus 4 extra pixels → last write at address 307199, 4 extra pixels dropped, pix_count=307200, err_flags[0]=1.
- Line with 1279 bytes (href drops with phase=1) → 639 writes for that line, err_flags[1]=1, next line starts at phase 0 with contiguous addresses.
- capture_en=0 at vsync fall → frame skipped, no wen_cam/frame_done, state_debug=3; next frame with capture_en=1 captures from address 0.
- Assert rst mid-line at pixel 100 → outputs zero next cycle; vsync still low blocks capture until the next vsync high→low, and the new frame starts at address 0.
